// File: rtl/vga_capture_rx.sv
// Receiver for the 8-bit TinyVGA pin stream: locks to the sync timing, recovers
// pixel coordinates and colour, flags timing errors and counts lit pixels per frame.
module vga_capture_rx #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [1:0]  pix_r,
  output logic [1:0]  pix_g,
  output logic [1:0]  pix_b,
  output logic        frame_start,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [18:0] lit_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] CNT_SAT = 10'h3ff;
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  // Stage 1: sampled pins and per-sample timing state.
  logic [7:0] s1_q;
  logic [7:0] s2_q;
  logic [9:0] hcnt_q;
  logic [9:0] hcnt_d;
  logic [9:0] vcnt_q;
  logic [9:0] vcnt_d;
  state_t     state_q;
  logic       herr_q;
  logic       verr_q;
  logic       vf_q;
  logic       was_locked_q;

  logic       hf;
  logic       vf;
  logic       herr_d;
  logic       verr_d;

  // Stage 2: output-side accumulation.
  logic [18:0] acc_q;
  logic        in_win;
  logic        valid_d;
  logic        lit_d;
  logic [1:0]  r_d;
  logic [1:0]  g_d;
  logic [1:0]  b_d;

  // A saturated counter means no reference edge has been seen yet, so it cannot be judged.
  always_comb begin
    hf     = s2_q[7] & ~s1_q[7];
    vf     = s2_q[3] & ~s1_q[3];
    herr_d = hf && (hcnt_q != CNT_SAT) && (hcnt_q != H_LAST);
    verr_d = vf && (vcnt_q != CNT_SAT) && (vcnt_q != V_LAST);

    hcnt_d = hcnt_q;
    if (hf) begin
      hcnt_d = '0;
    end else if (hcnt_q != CNT_SAT) begin
      hcnt_d = hcnt_q + 10'd1;
    end

    vcnt_d = vcnt_q;
    if (vf) begin
      vcnt_d = '0;
    end else if (hf && (vcnt_q != CNT_SAT)) begin
      vcnt_d = vcnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q         <= '0;
      s2_q         <= '0;
      hcnt_q       <= CNT_SAT;
      vcnt_q       <= CNT_SAT;
      state_q      <= ST_UNLOCKED;
      herr_q       <= 1'b0;
      verr_q       <= 1'b0;
      vf_q         <= 1'b0;
      was_locked_q <= 1'b0;
    end else begin
      s1_q         <= vga_in;
      s2_q         <= s1_q;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      herr_q       <= herr_d;
      verr_q       <= verr_d;
      vf_q         <= vf;
      was_locked_q <= (state_q == ST_LOCKED);

      // An erroring vsync edge still arms, so relock takes only one more clean frame.
      if (herr_d || verr_d) begin
        state_q <= vf ? ST_ARMED : ST_UNLOCKED;
      end else if (vf) begin
        case (state_q)
          ST_UNLOCKED: state_q <= ST_ARMED;
          ST_ARMED:    state_q <= ST_LOCKED;
          default:     state_q <= ST_LOCKED;
        endcase
      end
    end
  end

  always_comb begin
    in_win  = (hcnt_q >= H_START) && (hcnt_q <= H_END) &&
              (vcnt_q >= V_START) && (vcnt_q <= V_END);
    valid_d = (state_q == ST_LOCKED) && in_win;
    r_d     = {s2_q[0], s2_q[4]};
    g_d     = {s2_q[1], s2_q[5]};
    b_d     = {s2_q[2], s2_q[6]};
    lit_d   = valid_d && (|{r_d, g_d, b_d});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_r       <= '0;
      pix_g       <= '0;
      pix_b       <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      lit_count   <= '0;
      acc_q       <= '0;
    end else begin
      pix_valid   <= valid_d;
      pix_x       <= valid_d ? (hcnt_q - H_START) : 10'd0;
      pix_y       <= valid_d ? (vcnt_q - V_START) : 10'd0;
      pix_r       <= valid_d ? r_d : 2'd0;
      pix_g       <= valid_d ? g_d : 2'd0;
      pix_b       <= valid_d ? b_d : 2'd0;
      frame_start <= vf_q;
      locked      <= (state_q == ST_LOCKED);
      h_err       <= herr_q;
      v_err       <= verr_q;

      // Only a frame that was fully locked and ended cleanly publishes its count.
      if (vf_q) begin
        acc_q <= '0;
        if (was_locked_q && !verr_q) begin
          lit_count <= acc_q + 19'(lit_d);
        end
      end else begin
        acc_q <= acc_q + 19'(lit_d);
      end
    end
  end

endmodule

// File: tb/tb_vga_capture_rx.sv
// Scoreboard bench for vga_capture_rx on a shrunken 15x11 raster: the driver queues
// expected output events, a forked monitor pops and compares them as they appear.
module tb_vga_capture_rx;

  localparam int T_HA = 8, T_HF = 2, T_HS = 3, T_HB = 2;
  localparam int T_VA = 6, T_VF = 1, T_VS = 2, T_VB = 2;
  localparam int T_HTOT = T_HA + T_HF + T_HS + T_HB;   // 15
  localparam int T_VTOT = T_VA + T_VF + T_VS + T_VB;   // 11
  localparam int T_HST  = T_HS + T_HB;                 // 5
  localparam int T_VST  = T_VS + T_VB;                 // 4

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  vga_in = 8'h88;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [1:0]  pix_r;
  logic [1:0]  pix_g;
  logic [1:0]  pix_b;
  logic        frame_start;
  logic        locked;
  logic        h_err;
  logic        v_err;
  logic [18:0] lit_count;

  typedef struct {
    int          tag;
    logic        valid;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [1:0]  r;
    logic [1:0]  g;
    logic [1:0]  b;
    logic        fs;
    logic        lk;
    logic        he;
    logic        ve;
    logic [18:0] lit;
  } exp_t;

  exp_t sb_q[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  vga_capture_rx #(
    .H_ACTIVE(T_HA), .H_FRONT(T_HF), .H_SYNC(T_HS), .H_BACK(T_HB),
    .V_ACTIVE(T_VA), .V_FRONT(T_VF), .V_SYNC(T_VS), .V_BACK(T_VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vga_in(vga_in),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .frame_start(frame_start), .locked(locked),
    .h_err(h_err), .v_err(v_err), .lit_count(lit_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [7:0] enc(bit hs, bit vs, logic [1:0] r, logic [1:0] g, logic [1:0] b);
    return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
  endfunction

  // Returns {r, g, b} for an active pixel.
  function automatic logic [5:0] pat_rgb(int pat, int x, int y);
    logic [9:0] xv;
    logic [9:0] yv;
    xv = 10'(x);
    yv = 10'(y);
    case (pat)
      1: return (x >= 2 && x <= 5 && y >= 1 && y <= 3) ? 6'b110000 : 6'b000000;
      2: return (x == 7 && y == 5) ? 6'b000011 : 6'b000000;
      3: return {xv[1:0], yv[1:0], 2'b00};
      default: return 6'b000000;
    endcase
  endfunction

  task automatic drive(input logic [7:0] v, input bit has, input exp_t e);
    @(negedge clk);
    vga_in = v;
    if (has) begin
      e.tag = edge_cnt + 3;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    exp_t e;
    e = '{default: '0};
    for (int i = 0; i < n; i++) drive(8'h88, 1'b0, e);
  endtask

  // lk: locked right after this frame's vsync edge; lit: lit_count expected during the frame.
  task automatic send_frame(input int nlines, input int short_line, input int pat,
                            input bit lk, input bit ve, input int lit, input int limit);
    exp_t e;
    bit cur_lk;
    bit has;
    bit in_win;
    int len;
    int n;
    logic [5:0] rgb;
    cur_lk = lk;
    n = 0;
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_line) ? T_HTOT - 1 : T_HTOT;
      for (int p = 0; p < len; p++) begin
        if (limit >= 0 && n >= limit) return;
        in_win = (p >= T_HST) && (p < T_HST + T_HA) && (l >= T_VST) && (l < T_VST + T_VA);
        rgb = in_win ? pat_rgb(pat, p - T_HST, l - T_VST) : 6'b0;
        e = '{default: '0};
        has = 1'b0;
        if (l == 0 && p == 0) begin
          e.fs = 1'b1;
          e.ve = ve;
          has = 1'b1;
        end
        if (short_line >= 0 && l == short_line + 1 && p == 0) begin
          e.he = 1'b1;
          cur_lk = 1'b0;
          has = 1'b1;
        end
        if (in_win && cur_lk) begin
          e.valid = 1'b1;
          e.x = 10'(p - T_HST);
          e.y = 10'(l - T_VST);
          e.r = rgb[5:4];
          e.g = rgb[3:2];
          e.b = rgb[1:0];
          has = 1'b1;
        end
        e.lk = cur_lk;
        e.lit = 19'(lit);
        drive(enc(p >= T_HS, l >= T_VS, rgb[5:4], rgb[3:2], rgb[1:0]), has, e);
        n++;
      end
    end
  endtask

  task automatic check_zero(input string name);
    logic [49:0] got;
    got = {pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, frame_start, locked, h_err, v_err, lit_count};
    n_checks++;
    if (got == 50'd0) n_pass++;
    else $display("FAIL %s: outputs got 0x%h, expected all zero", name, got);
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (sb_q.size() > 0 && sb_q[0].tag < edge_cnt) begin
          e = sb_q.pop_front();
          n_checks++;
          $display("FAIL missing_event: event due at edge %0d absent (fs=%0b he=%0b ve=%0b v=%0b x=%0d y=%0d)",
                   e.tag, e.fs, e.he, e.ve, e.valid, e.x, e.y);
        end
        if (sb_q.size() > 0 && sb_q[0].tag == edge_cnt) begin
          e = sb_q.pop_front();
          n_checks++;
          if (pix_valid === e.valid && pix_x === e.x && pix_y === e.y && pix_r === e.r &&
              pix_g === e.g && pix_b === e.b && frame_start === e.fs && locked === e.lk &&
              h_err === e.he && v_err === e.ve && lit_count === e.lit) begin
            n_pass++;
          end else begin
            $display("FAIL event@%0d: got v=%0b x=%0d y=%0d r=%0d g=%0d b=%0d fs=%0b lk=%0b he=%0b ve=%0b lit=%0d; expected v=%0b x=%0d y=%0d r=%0d g=%0d b=%0d fs=%0b lk=%0b he=%0b ve=%0b lit=%0d",
                     edge_cnt, pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, frame_start, locked, h_err, v_err, lit_count,
                     e.valid, e.x, e.y, e.r, e.g, e.b, e.fs, e.lk, e.he, e.ve, e.lit);
          end
        end else if (pix_valid || frame_start || h_err || v_err) begin
          n_checks++;
          $display("FAIL unexpected_event@%0d: got v=%0b x=%0d y=%0d fs=%0b lk=%0b he=%0b ve=%0b, expected no event",
                   edge_cnt, pix_valid, pix_x, pix_y, frame_start, locked, h_err, v_err);
        end
      end
    end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    repeat (2) @(negedge clk);
    check_zero("reset_initial");
    #2 rst_n = 1'b1;
    idle(2);

    // nlines, short_line, pattern, locked, v_err, lit_count, sample limit
    send_frame(T_VTOT,     -1, 1, 1'b0, 1'b0,  0, -1);  // first VF arms
    send_frame(T_VTOT,     -1, 1, 1'b1, 1'b0,  0, -1);  // second VF locks
    send_frame(T_VTOT,     -1, 1, 1'b1, 1'b0, 12, -1);  // 4x3 red rectangle latched
    send_frame(T_VTOT,     -1, 2, 1'b1, 1'b0, 12, -1);  // single blue corner pixel
    send_frame(T_VTOT,      3, 1, 1'b1, 1'b0,  1, -1);  // line 3 one clock short
    send_frame(T_VTOT,     -1, 1, 1'b0, 1'b0,  1, -1);  // rearm, count held
    send_frame(T_VTOT,     -1, 1, 1'b1, 1'b0,  1, -1);  // relock, count held
    send_frame(T_VTOT + 1, -1, 2, 1'b1, 1'b0, 12, -1);  // one extra line
    send_frame(T_VTOT,     -1, 0, 1'b0, 1'b1, 12, -1);  // v_err arms, count held
    send_frame(T_VTOT,     -1, 3, 1'b1, 1'b0, 12, -1);  // relock, colour-bit pattern
    send_frame(T_VTOT,     -1, 0, 1'b1, 1'b0, 44, 5 * T_HTOT + 9);

    // Asynchronous reset mid-line while locked.
    @(negedge clk);
    #2;
    vga_in = 8'h88;
    rst_n = 1'b0;
    sb_q.delete();
    #1 check_zero("reset_mid_line");
    @(negedge clk);
    check_zero("reset_held");
    #2 rst_n = 1'b1;
    idle(2);
    send_frame(T_VTOT, -1, 1, 1'b0, 1'b0, 0, -1);
    send_frame(T_VTOT, -1, 1, 1'b1, 1'b0, 0, -1);
    idle(6);

    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending events, expected 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
